// File: rtl/spi_slv_regs.sv
// SPI mode-0 slave fronting a 2^AW-byte register file (cmd 0x02 write, 0x03 read).
// Build macro SPI_SLV_AUTOINC_EN: address auto-increments within a burst; otherwise it stays fixed.
module spi_slv_regs #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          spi_clk,
  input  logic          spi_ss,
  input  logic          spi_mosi,
  output logic          spi_miso,
  input  logic [AW-1:0] reg_addr_i,
  output logic [7:0]    reg_rdata_o,
  output logic          wr_pulse_o,
  output logic [AW-1:0] wr_addr_o
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    ADDR = 3'd2,
    WR   = 3'd3,
    RD   = 3'd4,
    SKIP = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    sclk_sync_q;
  logic [2:0]    ss_sync_q;
  logic [1:0]    mosi_sync_q;
  logic [1:0]    vld_q;
  logic          arm_q, arm_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    tx_q, tx_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] addr_nxt_s;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          dir_rd_q, dir_rd_d;
  logic          miso_q, miso_d;
  logic          pulse_q, pulse_d;
  logic          wr_en_s;
  logic [7:0]    byte_s;
  logic          sclk_rise_s, sclk_fall_s;
  logic          ss_fall_s, ss_rise_s;
  logic [7:0]    mem_q [DEPTH];

  // Bit [1] of each sync chain is the synchronized value, bit [2] its previous sample.
  assign sclk_rise_s = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall_s = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign ss_rise_s   = ss_sync_q[1] & ~ss_sync_q[2];
  assign ss_fall_s   = arm_q & ~ss_sync_q[1] & ss_sync_q[2];
  // A select held low across reset must not look like a fresh falling edge.
  assign arm_d       = arm_q | (vld_q[1] & ss_sync_q[1]);
  assign byte_s      = {rx_q[6:0], mosi_sync_q[1]};

`ifdef SPI_SLV_AUTOINC_EN
  assign addr_nxt_s = addr_q + {{(AW-1){1'b0}}, 1'b1};
`else
  assign addr_nxt_s = addr_q;
`endif

  assign reg_rdata_o = mem_q[reg_addr_i];
  assign spi_miso    = miso_q;
  assign wr_pulse_o  = pulse_q;
  assign wr_addr_o   = wr_addr_q;

  // Input synchronizers and post-reset arming of the select edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= 3'b000;
      ss_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
      vld_q       <= 2'b00;
      arm_q       <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], spi_clk};
      ss_sync_q   <= {ss_sync_q[1:0], spi_ss};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      vld_q       <= {vld_q[0], 1'b1};
      arm_q       <= arm_d;
    end
  end

  // Protocol FSM state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      rx_q      <= 8'h00;
      tx_q      <= 8'h00;
      addr_q    <= {AW{1'b0}};
      wr_addr_q <= {AW{1'b0}};
      dir_rd_q  <= 1'b0;
      miso_q    <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      wr_addr_q <= wr_addr_d;
      dir_rd_q  <= dir_rd_d;
      miso_q    <= miso_d;
      pulse_q   <= pulse_d;
    end
  end

  // Register file; a write lands on the clock after the 8th data rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (wr_en_s) begin
      mem_q[addr_q] <= byte_s;
    end
  end

  // Next-state, shift and output logic.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    wr_addr_d = wr_addr_q;
    dir_rd_d  = dir_rd_q;
    miso_d    = miso_q;
    pulse_d   = 1'b0;
    wr_en_s   = 1'b0;

    if (ss_rise_s) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      rx_d      = 8'h00;
      miso_d    = 1'b0;
    end else if (state_q == IDLE) begin
      miso_d = 1'b0;
      if (ss_fall_s) begin
        state_d   = CMD;
        bit_cnt_d = 3'd0;
        rx_d      = 8'h00;
      end else begin
        state_d = IDLE;
      end
    end else begin
      if (state_q != RD) begin
        miso_d = 1'b0;
      end else begin
        miso_d = miso_q;
      end

      if (sclk_rise_s) begin
        rx_d      = byte_s;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          case (state_q)
            CMD: begin
              if (byte_s == 8'h02) begin
                state_d  = ADDR;
                dir_rd_d = 1'b0;
              end else if (byte_s == 8'h03) begin
                state_d  = ADDR;
                dir_rd_d = 1'b1;
              end else begin
                state_d = SKIP;
              end
            end
            ADDR: begin
              addr_d = byte_s[AW-1:0];
              if (dir_rd_q) begin
                state_d = RD;
                tx_d    = mem_q[byte_s[AW-1:0]];
              end else begin
                state_d = WR;
              end
            end
            WR: begin
              wr_en_s   = 1'b1;
              pulse_d   = 1'b1;
              wr_addr_d = addr_q;
              addr_d    = addr_nxt_s;
            end
            default: state_d = state_q;
          endcase
        end else begin
          state_d = state_q;
        end
      end else if (sclk_fall_s && (state_q == RD)) begin
        miso_d = tx_q[7];
        // The 8th falling edge of a byte puts out its LSB and preloads the next byte.
        if (bit_cnt_q == 3'd7) begin
          addr_d = addr_nxt_s;
          tx_d   = mem_q[addr_nxt_s];
        end else begin
          tx_d = {tx_q[6:0], 1'b0};
        end
      end else begin
        state_d = state_q;
      end
    end
  end

endmodule

// File: tb/tb_spi_slv_regs.sv
// Directed self-checking bench for spi_slv_regs acting as a mode-0 SPI master.
// Expectations follow SPI_SLV_AUTOINC_EN when it is defined for the build.
module tb_spi_slv_regs;

  localparam int AW = 4;
`ifdef SPI_SLV_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          spi_clk  = 1'b0;
  logic          spi_ss   = 1'b1;
  logic          spi_mosi = 1'b0;
  logic          spi_miso;
  logic [AW-1:0] reg_addr_i = '0;
  logic [7:0]    reg_rdata_o;
  logic          wr_pulse_o;
  logic [AW-1:0] wr_addr_o;

  int n_cmp = 0;
  int n_err = 0;

  int         pulse_cnt = 0;
  logic [3:0] p_addr [64];
  logic [7:0] p_pre  [64];
  logic [7:0] p_post [64];
  logic [7:0] rdata_prev = 8'h00;

  spi_slv_regs #(.AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_clk    (spi_clk),
    .spi_ss     (spi_ss),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .reg_addr_i (reg_addr_i),
    .reg_rdata_o(reg_rdata_o),
    .wr_pulse_o (wr_pulse_o),
    .wr_addr_o  (wr_addr_o)
  );

  always #5 clk = ~clk;

  // Records each write pulse with the read-port value just before and after the commit.
  always @(negedge clk) begin
    if (wr_pulse_o === 1'b1) begin
      if (pulse_cnt < 64) begin
        p_addr[pulse_cnt] = wr_addr_o;
        p_pre[pulse_cnt]  = rdata_prev;
        p_post[pulse_cnt] = reg_rdata_o;
      end
      pulse_cnt = pulse_cnt + 1;
    end
    rdata_prev = reg_rdata_o;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge clk) spi_mosi = tx[i];
      repeat (8) @(negedge clk);
      rx[i]   = spi_miso;
      spi_clk = 1'b1;
      repeat (8) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic ss_low();
    @(negedge clk) spi_ss = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic ss_high();
    repeat (8) @(negedge clk);
    spi_ss = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic rd_mem(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk) reg_addr_i = a;
    #1 d = reg_rdata_o;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    repeat (3) @(negedge clk);
    n_cmp++; if (spi_miso !== 1'b0) begin n_err++; $display("FAIL reset_miso: got %b want 0", spi_miso); end
    n_cmp++; if (wr_pulse_o !== 1'b0) begin n_err++; $display("FAIL reset_pulse: got %b want 0", wr_pulse_o); end
    n_cmp++; if (wr_addr_o !== 4'h0) begin n_err++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr_o); end
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      rd_mem(a[3:0], d);
      n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL reset_mem[%0d]: got %h want 00", a, d); end
    end
  endtask

  task automatic test_write_burst();
    logic [7:0] r0, r1, r2, r3, d;
    int base;
    base = pulse_cnt;
    @(negedge clk) reg_addr_i = 4'h5;
    ss_low();
    spi_xfer(8'h02, r0); spi_xfer(8'h05, r1); spi_xfer(8'hA1, r2); spi_xfer(8'hB2, r3);
    ss_high();
    n_cmp++; if ({r0, r1, r2, r3} !== 32'h0) begin n_err++; $display("FAIL wr_miso: got %h want 00000000", {r0, r1, r2, r3}); end
    n_cmp++; if (pulse_cnt - base !== 2) begin n_err++; $display("FAIL wr_pulses: got %0d want 2", pulse_cnt - base); end
    n_cmp++; if (p_addr[base] !== 4'h5) begin n_err++; $display("FAIL wr_addr0: got %h want 5", p_addr[base]); end
    n_cmp++; if (p_addr[base+1] !== (AUTOINC ? 4'h6 : 4'h5)) begin n_err++; $display("FAIL wr_addr1: got %h want %h", p_addr[base+1], AUTOINC ? 4'h6 : 4'h5); end
    n_cmp++; if (p_pre[base] !== 8'h00) begin n_err++; $display("FAIL wr_same_clk_old: got %h want 00", p_pre[base]); end
    n_cmp++; if (p_post[base] !== 8'hA1) begin n_err++; $display("FAIL wr_same_clk_new: got %h want a1", p_post[base]); end
    rd_mem(4'h5, d);
    n_cmp++; if (d !== (AUTOINC ? 8'hA1 : 8'hB2)) begin n_err++; $display("FAIL wr_mem5: got %h want %h", d, AUTOINC ? 8'hA1 : 8'hB2); end
    rd_mem(4'h6, d);
    n_cmp++; if (d !== (AUTOINC ? 8'hB2 : 8'h00)) begin n_err++; $display("FAIL wr_mem6: got %h want %h", d, AUTOINC ? 8'hB2 : 8'h00); end
  endtask

  task automatic test_read();
    logic [7:0] r0, r1, d0, d1;
    int base;
    base = pulse_cnt;
    ss_low();
    spi_xfer(8'h03, r0); spi_xfer(8'h05, r1); spi_xfer(8'h00, d0); spi_xfer(8'h00, d1);
    ss_high();
    n_cmp++; if ({r0, r1} !== 16'h0) begin n_err++; $display("FAIL rd_hdr_miso: got %h want 0000", {r0, r1}); end
    n_cmp++; if (d0 !== (AUTOINC ? 8'hA1 : 8'hB2)) begin n_err++; $display("FAIL rd_byte0: got %h want %h", d0, AUTOINC ? 8'hA1 : 8'hB2); end
    n_cmp++; if (d1 !== 8'hB2) begin n_err++; $display("FAIL rd_byte1: got %h want b2", d1); end
    n_cmp++; if (spi_miso !== 1'b0) begin n_err++; $display("FAIL rd_miso_idle: got %b want 0", spi_miso); end
    n_cmp++; if (pulse_cnt - base !== 0) begin n_err++; $display("FAIL rd_pulses: got %0d want 0", pulse_cnt - base); end
  endtask

  task automatic test_wrap();
    logic [7:0] r, d0, d1, d;
    int base;
    base = pulse_cnt;
    ss_low();
    spi_xfer(8'h02, r); spi_xfer(8'h0F, r); spi_xfer(8'h11, r); spi_xfer(8'h22, r);
    ss_high();
    n_cmp++; if (p_addr[base] !== 4'hF) begin n_err++; $display("FAIL wrap_addr0: got %h want f", p_addr[base]); end
    n_cmp++; if (p_addr[base+1] !== (AUTOINC ? 4'h0 : 4'hF)) begin n_err++; $display("FAIL wrap_addr1: got %h want %h", p_addr[base+1], AUTOINC ? 4'h0 : 4'hF); end
    rd_mem(4'hF, d);
    n_cmp++; if (d !== (AUTOINC ? 8'h11 : 8'h22)) begin n_err++; $display("FAIL wrap_mem15: got %h want %h", d, AUTOINC ? 8'h11 : 8'h22); end
    rd_mem(4'h0, d);
    n_cmp++; if (d !== (AUTOINC ? 8'h22 : 8'h00)) begin n_err++; $display("FAIL wrap_mem0: got %h want %h", d, AUTOINC ? 8'h22 : 8'h00); end
    ss_low();
    spi_xfer(8'h03, r); spi_xfer(8'hFF, r); spi_xfer(8'h00, d0); spi_xfer(8'h00, d1);
    ss_high();
    n_cmp++; if (d0 !== (AUTOINC ? 8'h11 : 8'h22)) begin n_err++; $display("FAIL wrap_rd0: got %h want %h", d0, AUTOINC ? 8'h11 : 8'h22); end
    n_cmp++; if (d1 !== 8'h22) begin n_err++; $display("FAIL wrap_rd1: got %h want 22", d1); end
  endtask

  task automatic test_abort();
    logic [7:0] r, d;
    int base;
    base = pulse_cnt;
    ss_low();
    spi_xfer(8'h02, r); spi_xfer(8'h03, r); spi_bits(8'hFF, 5, r);
    ss_high();
    rd_mem(4'h3, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL abort_mem3: got %h want 00", d); end
    n_cmp++; if (pulse_cnt - base !== 0) begin n_err++; $display("FAIL abort_pulses: got %0d want 0", pulse_cnt - base); end
    ss_low();
    spi_xfer(8'h02, r); spi_xfer(8'h03, r); spi_xfer(8'h5A, r);
    ss_high();
    rd_mem(4'h3, d);
    n_cmp++; if (d !== 8'h5A) begin n_err++; $display("FAIL abort_next_mem3: got %h want 5a", d); end
    n_cmp++; if (pulse_cnt - base !== 1) begin n_err++; $display("FAIL abort_next_pulses: got %0d want 1", pulse_cnt - base); end
    n_cmp++; if (p_addr[base] !== 4'h3) begin n_err++; $display("FAIL abort_next_addr: got %h want 3", p_addr[base]); end
  endtask

  task automatic test_unknown_cmd();
    logic [7:0] r0, r1, r2, r3, d;
    int base;
    base = pulse_cnt;
    ss_low();
    spi_xfer(8'h9F, r0); spi_xfer(8'h11, r1); spi_xfer(8'h22, r2); spi_xfer(8'h33, r3);
    ss_high();
    n_cmp++; if ({r0, r1, r2, r3} !== 32'h0) begin n_err++; $display("FAIL unk_miso: got %h want 00000000", {r0, r1, r2, r3}); end
    n_cmp++; if (pulse_cnt - base !== 0) begin n_err++; $display("FAIL unk_pulses: got %0d want 0", pulse_cnt - base); end
    rd_mem(4'h1, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL unk_mem1: got %h want 00", d); end
    rd_mem(4'h2, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL unk_mem2: got %h want 00", d); end
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] r0, r1, r2, d;
    int base;
    base = pulse_cnt;
    @(negedge clk) reg_addr_i = 4'h3;
    ss_low();
    spi_xfer(8'h02, r0); spi_xfer(8'h07, r0);
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (spi_miso !== 1'b0) begin n_err++; $display("FAIL rstmid_miso: got %b want 0", spi_miso); end
    n_cmp++; if (wr_pulse_o !== 1'b0) begin n_err++; $display("FAIL rstmid_pulse: got %b want 0", wr_pulse_o); end
    n_cmp++; if (wr_addr_o !== 4'h0) begin n_err++; $display("FAIL rstmid_wr_addr: got %h want 0", wr_addr_o); end
    n_cmp++; if (reg_rdata_o !== 8'h00) begin n_err++; $display("FAIL rstmid_rdata: got %h want 00", reg_rdata_o); end
    @(negedge clk) rst_n = 1'b1;
    // Select is still low: this traffic must be ignored.
    spi_xfer(8'h02, r0); spi_xfer(8'h07, r1); spi_xfer(8'h77, r2);
    ss_high();
    n_cmp++; if ({r0, r1, r2} !== 24'h0) begin n_err++; $display("FAIL rstmid_ign_miso: got %h want 000000", {r0, r1, r2}); end
    n_cmp++; if (pulse_cnt - base !== 0) begin n_err++; $display("FAIL rstmid_pulses: got %0d want 0", pulse_cnt - base); end
    for (int a = 0; a < 16; a++) begin
      rd_mem(a[3:0], d);
      n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL rstmid_mem[%0d]: got %h want 00", a, d); end
    end
    ss_low();
    spi_xfer(8'h02, r0); spi_xfer(8'h07, r0); spi_xfer(8'h66, r0);
    ss_high();
    rd_mem(4'h7, d);
    n_cmp++; if (d !== 8'h66) begin n_err++; $display("FAIL rstmid_next_mem7: got %h want 66", d); end
    n_cmp++; if (pulse_cnt - base !== 1) begin n_err++; $display("FAIL rstmid_next_pulses: got %0d want 1", pulse_cnt - base); end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read();
    test_wrap();
    test_abort();
    test_unknown_cmd();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slv_regs.md
SPI_SLV_REGS -- requirements
Module: spi_slv_regs

Interface
- REQ-001: Parameter AW, default 4; address width, so memory depth is 2^AW bytes.
- REQ-002: clk  input  1  system clock; all state is clocked on the rising edge.
- REQ-003: rst_n  input  1  asynchronous active-low reset.
- REQ-004: spi_clk  input  1  SPI serial clock driven by the external master (mode 0, CPOL=0, CPHA=0).
- REQ-005: spi_ss  input  1  active-low slave select.
- REQ-006: spi_mosi  input  1  serial data from the master, MSB first.
- REQ-007: spi_miso  output  1  serial data to the master, MSB first.
- REQ-008: reg_addr_i  input  AW  local read address.
- REQ-009: reg_rdata_o  output  8  combinational read of mem[reg_addr_i].
- REQ-010: wr_pulse_o  output  1  one-clk pulse on each completed SPI write byte.
- REQ-011: wr_addr_o  output  AW  address of the last completed SPI write; valid when wr_pulse_o=1.

Function
- REQ-012: spi_clk, spi_ss and spi_mosi SHALL each pass a 2-flop synchronizer; edges are detected on the synchronized spi_clk. Operation is guaranteed for f_clk >= 8 x f_spi_clk.
- REQ-013: On a synchronized spi_clk rising edge with spi_ss low, the block SHALL shift in synchronized MOSI; on a falling edge, it SHALL shift out the next MISO bit.
- REQ-014: The FSM SHALL have the states IDLE, CMD, ADDR, WR, RD, SKIP; a spi_ss falling edge moves IDLE->CMD.
- REQ-015: After 8 bits in CMD: 0x02 goes to ADDR(write), 0x03 goes to ADDR(read), any other value goes to SKIP.
- REQ-016: After 8 bits in ADDR, the block SHALL latch addr = byte[AW-1:0] (upper bits ignored) and move to WR or RD.
- REQ-017: In WR, each completed byte SHALL write mem[addr] in the clk following the 8th rising edge, pulse wr_pulse_o for 1 clk with wr_addr_o=addr, then advance addr.
- REQ-018: On entering RD, mem[addr] SHALL load into the TX shift register so that its MSB is on spi_miso at the next spi_clk falling edge.
- REQ-019: In RD, after each 8th falling edge, the block SHALL advance addr and load the next byte.
- REQ-020: spi_miso SHALL be 0 in IDLE, CMD, ADDR, WR and SKIP, and whenever spi_ss is high.
- REQ-021: Address advance is addr+1 modulo 2^AW (wraps 2^AW-1 -> 0).
- REQ-022: A spi_ss rising edge in any state SHALL return the FSM to IDLE, discard any partial byte (no write, no pulse) and clear the bit counter.
- REQ-023: The bit counter is 3 bits and wraps 7->0 at each byte boundary.
- REQ-024: reg_rdata_o SHALL return the pre-write value when a SPI write to the same address commits in the same clk.

Reset
- REQ-025: With rst_n low, the block SHALL force the FSM to IDLE; clear bit counter, shift registers, addr and synchronizers (spi_ss synchronizer to 1); drive spi_miso=0, wr_pulse_o=0, wr_addr_o=0; and clear all memory bytes to 0x00.
- REQ-026: Reset asserted mid-transfer SHALL abort the transfer. After release, the block SHALL ignore all activity until the next spi_ss falling edge.

Configuration
- REQ-027: Macro SPI_SLV_AUTOINC_EN: when defined, address advances per REQ-017, REQ-019 and REQ-021.
- REQ-028: When SPI_SLV_AUTOINC_EN is undefined, addr SHALL stay fixed for the whole transaction: repeated writes overwrite one byte and repeated reads return the same byte. All else is unchanged.

Verification
- REQ-029: Write burst: 0x02,0x05,0xA1,0xB2 -> mem[5]=0xA1, mem[6]=0xB2; two wr_pulse_o pulses with wr_addr_o 5 then 6. Without SPI_SLV_AUTOINC_EN -> mem[5]=0xB2 and mem[6]=0x00.
- REQ-030: Read after write: 0x03,0x05 then 16 clocks -> MISO bytes 0xA1,0xB2; spi_miso=0 during the cmd and addr bytes.
- REQ-031: Wrap: 0x02,0x0F,0x11,0x22 (AW=4) -> mem[15]=0x11, mem[0]=0x22; a read from 0xFF returns mem[15] then mem[0].
- REQ-032: Abort: 0x02,0x03, then spi_ss high after 5 data bits -> mem[3] unchanged and no wr_pulse_o; the next transaction decodes normally.
- REQ-033: Unknown command 0x9F followed by 3 bytes -> no writes, spi_miso=0 throughout; rst_n pulsed mid-burst -> all outputs 0 and memory 0x00.
